// File: rtl/seg7_scan_capture_if.sv
// Scan-bus bundle for seg7_scan_capture: the sampled COM/ENS lines plus the
// rebuilt frame outputs. oERR_CNT exists only when SEG7_CAP_ERRCNT_EN is defined.
interface seg7_scan_capture_if;
  logic [7:0]  iS_COM;
  logic [6:0]  iS_ENS;
  logic [55:0] oSEG_ALL;
  logic [31:0] oHEX_ALL;
  logic [7:0]  oHEX_VALID;
  logic        oFRAME;
  logic        oLOCK;
  logic        oERR;
`ifdef SEG7_CAP_ERRCNT_EN
  logic [7:0]  oERR_CNT;
`endif

  modport master (
    output iS_COM, iS_ENS,
    input  oSEG_ALL, oHEX_ALL, oHEX_VALID, oFRAME, oLOCK, oERR
`ifdef SEG7_CAP_ERRCNT_EN
    , input oERR_CNT
`endif
  );

  modport slave (
    input  iS_COM, iS_ENS,
    output oSEG_ALL, oHEX_ALL, oHEX_VALID, oFRAME, oLOCK, oERR
`ifdef SEG7_CAP_ERRCNT_EN
    , output oERR_CNT
`endif
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Receive side of an 8-digit multiplexed 7-segment scan bus: rebuilds one frame
// of segment patterns and decodes them to hex. Optional macro SEG7_CAP_ERRCNT_EN adds oERR_CNT.
module seg7_scan_capture #(
  parameter int STABLE_CYC = 1
) (
  input logic            iCLK,
  input logic            nRST,
  seg7_scan_capture_if.slave bus
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t      state, state_next;
  logic [2:0]  expected, expected_next;
  logic [6:0]  shadow [7];
  logic [14:0] pair, prev_pair;
  logic [3:0]  stab_cnt;
  logic [4:0]  run_len;
  logic        accept;
  logic [7:0]  zeros;
  logic        is_blank, is_active, is_illegal;
  logic [2:0]  digit;
  logic        shadow_we, err_now, frame_now;
  logic [55:0] frame_seg;
  logic [31:0] frame_hex;
  logic [7:0]  frame_valid;
  logic [55:0] seg_all;
  logic [31:0] hex_all;
  logic [7:0]  hex_valid;
  logic        frame_q, lock_q, err_q;

  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    case (seg)
      7'h7E: return {1'b1, 4'h0};
      7'h30: return {1'b1, 4'h1};
      7'h6D: return {1'b1, 4'h2};
      7'h79: return {1'b1, 4'h3};
      7'h33: return {1'b1, 4'h4};
      7'h5B: return {1'b1, 4'h5};
      7'h5F: return {1'b1, 4'h6};
      7'h70: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h7B: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h1F: return {1'b1, 4'hB};
      7'h4E: return {1'b1, 4'hC};
      7'h3D: return {1'b1, 4'hD};
      7'h4F: return {1'b1, 4'hE};
      7'h47: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  // run_len counts the current cycle, so a pair is accepted exactly once on its STABLE_CYC-th cycle
  assign pair    = {bus.iS_COM, bus.iS_ENS};
  assign run_len = (pair == prev_pair) ? ({1'b0, stab_cnt} + 5'd1) : 5'd1;
  assign accept  = (run_len == 5'(STABLE_CYC));

  assign zeros      = ~bus.iS_COM;
  assign is_blank   = (zeros == 8'h00);
  assign is_active  = !is_blank && ((zeros & (zeros - 8'd1)) == 8'h00);
  assign is_illegal = !is_blank && !is_active;

  always_comb begin
    digit = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (zeros[k]) digit = 3'(k);
    end
  end

  always_comb begin
    state_next    = state;
    expected_next = expected;
    shadow_we     = 1'b0;
    err_now       = 1'b0;
    frame_now     = 1'b0;
    if (accept && is_illegal) begin
      err_now       = 1'b1;
      state_next    = HUNT;
      expected_next = 3'd0;
    end else if (accept && is_active) begin
      case (state)
        HUNT: begin
          if (digit == 3'd0) begin
            shadow_we     = 1'b1;
            expected_next = 3'd1;
            state_next    = CAPTURE;
          end
        end
        CAPTURE: begin
          if (digit == expected) begin
            if (digit == 3'd7) begin
              frame_now     = 1'b1;
              expected_next = 3'd0;
            end else begin
              shadow_we     = 1'b1;
              expected_next = expected + 3'd1;
            end
          end else if (digit == 3'd0) begin
            err_now       = 1'b1;
            shadow_we     = 1'b1;
            expected_next = 3'd1;
          end else begin
            err_now       = 1'b1;
            state_next    = HUNT;
            expected_next = 3'd0;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Digit 7 is never shadowed: the live ENS completes the frame directly
  always_comb begin
    frame_seg   = '0;
    frame_hex   = '0;
    frame_valid = '0;
    for (int k = 0; k < 7; k++) frame_seg[7*k +: 7] = shadow[k];
    frame_seg[55:49] = bus.iS_ENS;
    for (int k = 0; k < 8; k++) begin
      {frame_valid[k], frame_hex[4*k +: 4]} = hex_decode(frame_seg[7*k +: 7]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      state     <= HUNT;
      expected  <= 3'd0;
      prev_pair <= '0;
      stab_cnt  <= '0;
      for (int k = 0; k < 7; k++) shadow[k] <= '0;
      seg_all   <= '0;
      hex_all   <= '0;
      hex_valid <= '0;
      frame_q   <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      expected  <= expected_next;
      prev_pair <= pair;
      stab_cnt  <= (run_len > 5'd15) ? 4'd15 : run_len[3:0];
      for (int k = 0; k < 7; k++) begin
        if (shadow_we && digit == 3'(k)) shadow[k] <= bus.iS_ENS;
      end
      frame_q <= frame_now;
      err_q   <= err_now;
      if (err_now) lock_q <= 1'b0;
      else if (frame_now) lock_q <= 1'b1;
      if (frame_now) begin
        seg_all   <= frame_seg;
        hex_all   <= frame_hex;
        hex_valid <= frame_valid;
      end
    end
  end

`ifdef SEG7_CAP_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge iCLK) begin
    if (!nRST) err_cnt <= '0;
    else if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign bus.oERR_CNT = err_cnt;
`endif

  assign bus.oSEG_ALL   = seg_all;
  assign bus.oHEX_ALL   = hex_all;
  assign bus.oHEX_VALID = hex_valid;
  assign bus.oFRAME     = frame_q;
  assign bus.oLOCK      = lock_q;
  assign bus.oERR       = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: one instance with STABLE_CYC=1 driven from a
// vector table, one with STABLE_CYC=3 for the stability cases.
module tb_seg7_scan_capture;

  typedef struct {
    logic [7:0]  com;
    logic [6:0]  ens;
    logic        frame;
    logic        err;
    logic        lock;
    logic        chk;
    logic [55:0] seg;
    logic [31:0] hex;
    logic [7:0]  valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failures = 0;
  vec_t vecs[$];
  logic [6:0] ens_tab [8];

  always #5 clk = ~clk;

  seg7_scan_capture_if bus1();
  seg7_scan_capture_if bus3();

  seg7_scan_capture #(.STABLE_CYC(1)) dut1 (.iCLK(clk), .nRST(rst_n), .bus(bus1));
  seg7_scan_capture #(.STABLE_CYC(3)) dut3 (.iCLK(clk), .nRST(rst_n), .bus(bus3));

  function automatic logic [7:0] com_of(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  function automatic logic [55:0] std_seg(input logic [6:0] d3);
    logic [55:0] s;
    for (int k = 0; k < 8; k++) s[7*k +: 7] = (k == 3) ? d3 : ens_tab[k];
    return s;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    tests++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  // Drives one scan slot on the chosen bus, then samples just after the edge
  task automatic apply_stimulus(input bit to3, input logic [7:0] com, input logic [6:0] ens);
    if (to3) begin
      bus3.iS_COM = com;
      bus3.iS_ENS = ens;
    end else begin
      bus1.iS_COM = com;
      bus1.iS_ENS = ens;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] com, input logic [6:0] ens,
                         input logic f, input logic e, input logic l);
    vec_t v;
    v.com = com; v.ens = ens; v.frame = f; v.err = e; v.lock = l;
    v.chk = 1'b0; v.seg = '0; v.hex = '0; v.valid = '0;
    vecs.push_back(v);
  endtask

  task automatic add_scan(input int first, input int last, input logic [6:0] d3,
                          input logic lock_mid, input logic completes);
    for (int k = first; k <= last; k++) begin
      logic f;
      f = completes && (k == 7);
      add_vec(com_of(k), (k == 3) ? d3 : ens_tab[k], f, 1'b0, f ? 1'b1 : lock_mid);
    end
  endtask

  task automatic mark_last(input logic [55:0] seg, input logic [31:0] hex, input logic [7:0] valid);
    vecs[vecs.size()-1].chk   = 1'b1;
    vecs[vecs.size()-1].seg   = seg;
    vecs[vecs.size()-1].hex   = hex;
    vecs[vecs.size()-1].valid = valid;
  endtask

  initial begin
    int frames;
    ens_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

    // Clean frame, then a frame with an undecodable digit 3
    add_scan(0, 7, 7'h79, 1'b0, 1'b1);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b1);
    mark_last(std_seg(7'h79), 32'h76543210, 8'hFF);
    add_scan(0, 7, 7'h00, 1'b1, 1'b1);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b1);
    mark_last(std_seg(7'h00), 32'h76540210, 8'hF7);
    // Out-of-order digit, then digits ignored in HUNT, then relock
    add_scan(0, 2, 7'h79, 1'b1, 1'b0);
    add_vec(com_of(5), ens_tab[5], 1'b0, 1'b1, 1'b0);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b0);
    add_scan(6, 7, 7'h79, 1'b0, 1'b0);
    add_scan(0, 7, 7'h79, 1'b0, 1'b1);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b1);
    mark_last(std_seg(7'h79), 32'h76543210, 8'hFF);
    // Two commons low at once
    add_vec(8'b11110011, 7'h00, 1'b0, 1'b1, 1'b0);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b0);
    add_scan(0, 7, 7'h79, 1'b0, 1'b1);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b1);
    // Early digit 0 restarts the frame rather than dropping to HUNT
    add_scan(0, 1, 7'h79, 1'b1, 1'b0);
    add_vec(com_of(0), ens_tab[0], 1'b0, 1'b1, 1'b0);
    add_scan(1, 7, 7'h79, 1'b0, 1'b1);
    add_vec(8'hFF, 7'h00, 1'b0, 1'b0, 1'b1);
    mark_last(std_seg(7'h79), 32'h76543210, 8'hFF);

    rst_n = 1'b0;
    bus1.iS_COM = 8'hFF; bus1.iS_ENS = 7'h00;
    bus3.iS_COM = 8'hFF; bus3.iS_ENS = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset frame", 64'(bus1.oFRAME), 64'd0);
    check_output("reset lock", 64'(bus1.oLOCK), 64'd0);
    check_output("reset err", 64'(bus1.oERR), 64'd0);
    check_output("reset hex", 64'(bus1.oHEX_ALL), 64'd0);
    check_output("reset valid", 64'(bus1.oHEX_VALID), 64'd0);
    check_output("reset seg", 64'(bus1.oSEG_ALL), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(1'b0, vecs[i].com, vecs[i].ens);
      check_output($sformatf("vec%0d frame", i), 64'(bus1.oFRAME), 64'(vecs[i].frame));
      check_output($sformatf("vec%0d err", i), 64'(bus1.oERR), 64'(vecs[i].err));
      check_output($sformatf("vec%0d lock", i), 64'(bus1.oLOCK), 64'(vecs[i].lock));
      if (vecs[i].chk) begin
        check_output($sformatf("vec%0d seg", i), 64'(bus1.oSEG_ALL), 64'(vecs[i].seg));
        check_output($sformatf("vec%0d hex", i), 64'(bus1.oHEX_ALL), 64'(vecs[i].hex));
        check_output($sformatf("vec%0d valid", i), 64'(bus1.oHEX_VALID), 64'(vecs[i].valid));
      end
    end
`ifdef SEG7_CAP_ERRCNT_EN
    check_output("errcnt after table", 64'(bus1.oERR_CNT), 64'd3);
`endif

    // Reset in the middle of a frame discards it
    for (int k = 0; k <= 4; k++) apply_stimulus(1'b0, com_of(k), ens_tab[k]);
    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'hFF, 7'h00);
    check_output("midreset frame", 64'(bus1.oFRAME), 64'd0);
    check_output("midreset lock", 64'(bus1.oLOCK), 64'd0);
    check_output("midreset hex", 64'(bus1.oHEX_ALL), 64'd0);
    check_output("midreset valid", 64'(bus1.oHEX_VALID), 64'd0);
    check_output("midreset seg", 64'(bus1.oSEG_ALL), 64'd0);
`ifdef SEG7_CAP_ERRCNT_EN
    check_output("midreset errcnt", 64'(bus1.oERR_CNT), 64'd0);
`endif
    rst_n = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      apply_stimulus(1'b0, com_of(k), ens_tab[k]);
      check_output($sformatf("resume d%0d frame", k), 64'(bus1.oFRAME), 64'd0);
      check_output($sformatf("resume d%0d err", k), 64'(bus1.oERR), 64'd0);
    end
    for (int k = 0; k <= 7; k++) begin
      apply_stimulus(1'b0, com_of(k), ens_tab[k]);
      check_output($sformatf("postreset d%0d frame", k), 64'(bus1.oFRAME), 64'(k == 7));
    end
    check_output("postreset hex", 64'(bus1.oHEX_ALL), 64'h76543210);
    apply_stimulus(1'b0, 8'hFF, 7'h00);

    // STABLE_CYC=3: two-cycle holds are too short, four-cycle holds accept once each
    for (int k = 0; k <= 7; k++) begin
      for (int c = 0; c < 2; c++) begin
        apply_stimulus(1'b1, com_of(k), ens_tab[k]);
        check_output($sformatf("short d%0d.%0d frame", k, c), 64'(bus3.oFRAME), 64'd0);
        check_output($sformatf("short d%0d.%0d err", k, c), 64'(bus3.oERR), 64'd0);
      end
    end
    apply_stimulus(1'b1, 8'hFF, 7'h00);
    check_output("short lock", 64'(bus3.oLOCK), 64'd0);
    frames = 0;
    for (int k = 0; k <= 7; k++) begin
      for (int c = 0; c < 4; c++) begin
        apply_stimulus(1'b1, com_of(k), ens_tab[k]);
        if (bus3.oFRAME === 1'b1) frames++;
        check_output($sformatf("long d%0d.%0d frame", k, c), 64'(bus3.oFRAME),
                     64'((k == 7) && (c == 2)));
        check_output($sformatf("long d%0d.%0d err", k, c), 64'(bus3.oERR), 64'd0);
      end
    end
    check_output("long frame count", 64'(frames), 64'd1);
    check_output("long lock", 64'(bus3.oLOCK), 64'd1);
    check_output("long hex", 64'(bus3.oHEX_ALL), 64'h76543210);
    check_output("long valid", 64'(bus3.oHEX_VALID), 64'hFF);
`ifdef SEG7_CAP_ERRCNT_EN
    check_output("long errcnt", 64'(bus3.oERR_CNT), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
